l2_arbiter: RTL and testbench

Shares the single L2 read port between the L1 instruction cache (fetch side) and the L1 data cache (memory side). Each requester raises a miss request carrying a block address. The arbiter grants one requester at a time (round-robin), runs a single outstanding L2 read, and returns the 512-bit block to the winner. It sits between the two L1 caches and the L2 and produces the per-cache block, address and stall signals those caches consume.

---
 rtl/l2_arbiter.sv | 124 ++++++++++++
 tb/tb_l2_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the single L2 read port between the icache and dcache.
// One outstanding L2 read at a time; the returned block is registered per requester.
module l2_arbiter #(
    parameter int BLOCK_W = 512,
    parameter int OFF_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               ic_req,
    input  logic [31:0]        ic_addr,
    input  logic               ic_cancel,
    input  logic               dc_req,
    input  logic [31:0]        dc_addr,

    output logic [BLOCK_W-1:0] ic_L2_block_read,
    output logic [31:0]        ic_L2_addr_read,
    output logic               ic_valid,
    output logic               ic_L2_stall,
    output logic [BLOCK_W-1:0] dc_L2_block_read,
    output logic [31:0]        dc_L2_addr_read,
    output logic               dc_valid,
    output logic               dc_L2_stall,

    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_ready,
    input  logic               mem_rvalid,
    input  logic [BLOCK_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last_grant, last_nxt;
    logic        drop, drop_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [31:0] sel_addr;
    logic        ic_cand, grant_d, cancel_hit, cap;

    assign ic_cand    = ic_req & ~ic_cancel;
    // On a tie the dcache wins only if the icache took the previous grant.
    assign grant_d    = dc_req & (~ic_cand | (last_grant == OWN_I));
    assign sel_addr   = grant_d ? dc_addr : ic_addr;
    assign cancel_hit = ic_cancel & (owner == OWN_I) & ((state == ISSUE) | (state == WAIT));

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_grant;
        drop_nxt  = drop;
        addr_nxt  = addr_q;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (ic_cand || dc_req) begin
                    owner_nxt = grant_d;
                    last_nxt  = grant_d;
                    drop_nxt  = 1'b0;
                    addr_nxt  = {sel_addr[31:OFF_W], {OFF_W{1'b0}}};
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    cap = 1'b1;
                    // A cancel landing together with the data still abandons the transfer.
                    state_nxt = (drop || cancel_hit) ? IDLE : RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cancel_hit) drop_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_D;
            drop       <= 1'b0;
            addr_q     <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_nxt;
            drop       <= drop_nxt;
            addr_q     <= addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic_L2_block_read <= '0;
            ic_L2_addr_read  <= '0;
            dc_L2_block_read <= '0;
            dc_L2_addr_read  <= '0;
        end else if (cap) begin
            if (owner == OWN_D) begin
                dc_L2_block_read <= mem_rdata;
                dc_L2_addr_read  <= addr_q;
            end else begin
                ic_L2_block_read <= mem_rdata;
                ic_L2_addr_read  <= addr_q;
            end
        end
    end

    assign mem_req     = (state == ISSUE);
    assign mem_addr    = addr_q;
    assign ic_valid    = (state == RESP) & (owner == OWN_I);
    assign dc_valid    = (state == RESP) & (owner == OWN_D);
    assign ic_L2_stall = ic_req & ~ic_valid;
    assign dc_L2_stall = dc_req & ~dc_valid;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: stimulus pushes expected L2 addresses and block
// deliveries into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_l2_arbiter;
    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ic_req = 1'b0, ic_cancel = 1'b0, dc_req = 1'b0;
    logic [31:0]   ic_addr = '0, dc_addr = '0;
    logic [BW-1:0] ic_L2_block_read, dc_L2_block_read;
    logic [31:0]   ic_L2_addr_read, dc_L2_addr_read;
    logic          ic_valid, ic_L2_stall, dc_valid, dc_L2_stall;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [BW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    l2_arbiter #(.BLOCK_W(BW), .OFF_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_cancel(ic_cancel),
        .dc_req(dc_req), .dc_addr(dc_addr),
        .ic_L2_block_read(ic_L2_block_read), .ic_L2_addr_read(ic_L2_addr_read),
        .ic_valid(ic_valid), .ic_L2_stall(ic_L2_stall),
        .dc_L2_block_read(dc_L2_block_read), .dc_L2_addr_read(dc_L2_addr_read),
        .dc_valid(dc_valid), .dc_L2_stall(dc_L2_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic          d;
        logic [31:0]   addr;
        logic [BW-1:0] data;
    } resp_t;

    resp_t       exp_resp[$];
    logic [31:0] exp_mem[$];
    resp_t       mon_e;
    logic [31:0] mon_a;
    int          checks = 0;
    int          errors = 0;

    localparam logic [BW-1:0] PA0 = {16{32'hA0A0_0001}};
    localparam logic [BW-1:0] PA1 = {16{32'hA1A1_0002}};
    localparam logic [BW-1:0] PA2 = {16{32'hA2A2_0003}};
    localparam logic [BW-1:0] PA3 = {16{32'hA3A3_0004}};
    localparam logic [BW-1:0] PB  = {8{64'h0123_4567_89AB_CDEF}};
    localparam logic [BW-1:0] PC  = {16{32'hC0DE_F00D}};
    localparam logic [BW-1:0] PD  = {16{32'hDEAD_BEEF}};
    localparam logic [BW-1:0] PE  = {16{32'h5555_AAAA}};
    localparam logic [BW-1:0] PF  = {16{32'hFACE_0FF1}};
    localparam logic [BW-1:0] PJ  = {16{32'h1111_2222}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // L2 model: waits (bounded) for mem_req, stalls mem_ready, then returns data.
    task automatic serve(input int rdy_wait, input int lat, input logic [31:0] req_addr,
                         input logic [BW-1:0] d, output int waited);
        waited = 0;
        while (!mem_req && waited < 50) begin
            tick();
            waited++;
        end
        if (!mem_req) begin
            checks++;
            errors++;
            $display("FAIL mem_req_timeout actual=0 required=1");
        end else begin
            for (int i = 0; i < rdy_wait; i++) begin
                chk("hold_req", 32'(mem_req), 32'd1);
                chk("hold_addr", mem_addr, req_addr);
                tick();
            end
            chk("accept_addr", mem_addr, req_addr);
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            repeat (lat) tick();
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    function automatic resp_t mk(input logic d, input logic [31:0] a, input logic [BW-1:0] p);
        resp_t r;
        r.d = d; r.addr = a; r.data = p;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ic_valid && dc_valid) begin
                checks++;
                errors++;
                $display("FAIL both_valid actual=11 required=one-hot");
            end else if (ic_valid || dc_valid) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid ic=%0d dc=%0d required=none", ic_valid, dc_valid);
                end else begin
                    mon_e = exp_resp.pop_front();
                    chk("resp_side_d", 32'(dc_valid), 32'(mon_e.d));
                    chk("resp_addr", dc_valid ? dc_L2_addr_read : ic_L2_addr_read, mon_e.addr);
                    chk_blk("resp_data", dc_valid ? dc_L2_block_read : ic_L2_block_read, mon_e.data);
                end
            end
            if (mem_req && mem_ready) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept addr=%0h required=none", mem_addr);
                end else begin
                    mon_a = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, mon_a);
                end
            end
            chk("ic_stall", 32'(ic_L2_stall), 32'(ic_req & ~ic_valid));
            chk("dc_stall", 32'(dc_L2_stall), 32'(dc_req & ~dc_valid));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // ---- reset state
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_valids", 32'({ic_valid, dc_valid}), 32'd0);
        chk_blk("rst_ic_blk", ic_L2_block_read, '0);
        chk_blk("rst_dc_blk", dc_L2_block_read, '0);
        chk("rst_ic_addr", ic_L2_addr_read, 32'd0);
        chk("rst_dc_addr", dc_L2_addr_read, 32'd0);
        ic_req = 1'b1; dc_req = 1'b1; #1;
        chk("rst_ic_stall", 32'(ic_L2_stall), 32'd1);
        chk("rst_dc_stall", 32'(dc_L2_stall), 32'd1);
        ic_req = 1'b0; dc_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---- simultaneous requests: I first, then alternate while both held
        ic_addr = 32'h0000_107F;
        dc_addr = 32'h8000_0005;
        exp_mem.push_back(32'h0000_1040); exp_resp.push_back(mk(1'b0, 32'h0000_1040, PA0));
        exp_mem.push_back(32'h8000_0000); exp_resp.push_back(mk(1'b1, 32'h8000_0000, PA1));
        exp_mem.push_back(32'h0000_1040); exp_resp.push_back(mk(1'b0, 32'h0000_1040, PA2));
        exp_mem.push_back(32'h8000_0000); exp_resp.push_back(mk(1'b1, 32'h8000_0000, PA3));
        ic_req = 1'b1; dc_req = 1'b1;
        serve(0, 0, 32'h0000_1040, PA0, w);
        chk("first_issue_lat", 32'(w), 32'd1);
        serve(0, 0, 32'h8000_0000, PA1, w);
        chk("b2b_gap", 32'(w), 32'd2);
        serve(0, 1, 32'h0000_1040, PA2, w);
        chk("b2b_gap", 32'(w), 32'd2);
        serve(0, 1, 32'h8000_0000, PA3, w);
        chk("b2b_gap", 32'(w), 32'd2);
        ic_req = 1'b0; dc_req = 1'b0;
        tick();

        // ---- single icache miss
        ic_addr = 32'h0000_1234;
        ic_req  = 1'b1;
        exp_mem.push_back(32'h0000_1200); exp_resp.push_back(mk(1'b0, 32'h0000_1200, PB));
        chk("idle_no_req", 32'(mem_req), 32'd0);
        tick();
        chk("issue_cycle1", 32'(mem_req), 32'd1);
        serve(0, 2, 32'h0000_1200, PB, w);
        chk("ic_valid_pulse", 32'(ic_valid), 32'd1);
        chk("ic_stall_drop", 32'(ic_L2_stall), 32'd0);
        chk_blk("ic_block", ic_L2_block_read, PB);
        chk("ic_addr_read", ic_L2_addr_read, 32'h0000_1200);
        chk("dc_valid_quiet", 32'(dc_valid), 32'd0);
        ic_req = 1'b0;
        tick();
        chk("ic_valid_one_cycle", 32'(ic_valid), 32'd0);

        // ---- ISSUE backpressure (dcache)
        dc_addr = 32'hABCD_EF7F;
        dc_req  = 1'b1;
        exp_mem.push_back(32'hABCD_EF40); exp_resp.push_back(mk(1'b1, 32'hABCD_EF40, PC));
        serve(5, 1, 32'hABCD_EF40, PC, w);
        dc_req = 1'b0;
        chk("nonowner_ic_addr", ic_L2_addr_read, 32'h0000_1200);
        chk_blk("nonowner_ic_blk", ic_L2_block_read, PB);
        tick();

        // ---- cancel in WAIT with a dcache request pending
        ic_addr = 32'h2000_0040;
        dc_addr = 32'h3000_0080;
        exp_mem.push_back(32'h2000_0040);
        exp_mem.push_back(32'h3000_0080); exp_resp.push_back(mk(1'b1, 32'h3000_0080, PE));
        ic_req = 1'b1; dc_req = 1'b1;
        tick();
        chk("cancel_issue_addr", mem_addr, 32'h2000_0040);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        ic_cancel = 1'b1; ic_req = 1'b0;
        tick();
        ic_cancel = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = PD;
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("cancel_no_ic_valid", 32'(ic_valid), 32'd0);
        chk("cancel_idle_no_req", 32'(mem_req), 32'd0);
        tick();
        chk("cancel_then_d_req", 32'(mem_req), 32'd1);
        chk("cancel_then_d_addr", mem_addr, 32'h3000_0080);
        serve(0, 1, 32'h3000_0080, PE, w);
        dc_req = 1'b0;
        tick();

        // ---- ic_cancel while D owns has no effect
        dc_addr = 32'h4000_00C0;
        dc_req  = 1'b1;
        exp_mem.push_back(32'h4000_00C0); exp_resp.push_back(mk(1'b1, 32'h4000_00C0, PF));
        tick();
        ic_cancel = 1'b1;
        tick();
        ic_cancel = 1'b0;
        serve(0, 2, 32'h4000_00C0, PF, w);
        chk("d_cancel_ignored", 32'(dc_valid), 32'd1);
        chk_blk("d_cancel_blk", dc_L2_block_read, PF);
        dc_req = 1'b0;
        tick();

        // ---- async reset while in WAIT
        ic_addr = 32'h5000_0000;
        ic_req  = 1'b1;
        exp_mem.push_back(32'h5000_0000);
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset_mem_req", 32'(mem_req), 32'd0);
        chk("areset_valids", 32'({ic_valid, dc_valid}), 32'd0);
        chk("areset_mem_addr", mem_addr, 32'd0);
        chk_blk("areset_ic_blk", ic_L2_block_read, '0);
        ic_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = PJ;
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("stray_rvalid_valids", 32'({ic_valid, dc_valid}), 32'd0);
        chk("stray_rvalid_req", 32'(mem_req), 32'd0);
        tick();
        chk("stray_rvalid_valids2", 32'({ic_valid, dc_valid}), 32'd0);
        chk_blk("stray_rvalid_blk", ic_L2_block_read, '0);
        tick();

        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
